// File: rtl/display_pkg.sv
// Shared definitions for the VGA card renderers.
//
// Holds the default board geometry, the card-type code width, the colour
// constants and the compositing source selector. It also provides
// row_top(), which gives the top scanline of a card row, including the extra
// offset for rows below the board/hand divider.
package display_pkg;

  localparam int DEF_COLS         = 18;
  localparam int DEF_ROWS         = 8;
  localparam int DEF_TYPE_W       = 6;
  localparam int DEF_CARD_W       = 32;
  localparam int DEF_CARD_H       = 46;
  localparam int DEF_X0           = 32;
  localparam int DEF_Y0           = 19;
  localparam int DEF_ROW_PITCH    = 55;
  localparam int DEF_GAP_ROW      = 6;
  localparam int DEF_GAP_EXTRA    = 11;
  localparam int DEF_EMPTY_TYPE   = 54;
  localparam int DEF_FRAME_T      = 2;
  localparam int DEF_BLINK_FRAMES = 32;

  localparam logic [11:0] DEF_FRAME_COLOR  = 12'hFEC;
  localparam logic [11:0] DEF_CURSOR_COLOR = 12'h0F0;
  localparam logic [11:0] DEF_BG_COLOR     = 12'h000;

  // Source of the final pixel, chosen one stage early so that the output
  // stage is just a 4:1 mux in front of the ROM data.
  typedef enum logic [1:0] {
    SRC_BG     = 2'd0,
    SRC_ROM    = 2'd1,
    SRC_FRAME  = 2'd2,
    SRC_CURSOR = 2'd3
  } pix_src_e;

  // Top scanline of card row r.
  function automatic int row_top(input int r, input int y0, input int pitch,
                                 input int gap_row, input int gap_extra);
    return y0 + r * pitch + ((r >= gap_row) ? gap_extra : 0);
  endfunction

endpackage

// File: rtl/card_grid_locate.sv
// Combinational locator for a grid of cards.
//
// Maps a VGA pixel position to a grid slot and to a pixel inside that card.
// Columns are found by a shift, because the card width is a power of two.
// Rows have an irregular pitch (the divider gap), so each row has its own
// comparator and no divider is needed.
//
// Ports:
//   h_cnt, v_cnt : pixel position from the VGA timing generator
//   hit          : the position lies inside a card rectangle
//   pos          : slot index row*COLS+col (0 on a miss)
//   px, py       : pixel offset inside the card (0 on a miss)
module card_grid_locate
  import display_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int CARD_W    = DEF_CARD_W,
  parameter int CARD_H    = DEF_CARD_H,
  parameter int X0        = DEF_X0,
  parameter int Y0        = DEF_Y0,
  parameter int ROW_PITCH = DEF_ROW_PITCH,
  parameter int GAP_ROW   = DEF_GAP_ROW,
  parameter int GAP_EXTRA = DEF_GAP_EXTRA
) (
  input  logic [9:0]                       h_cnt,
  input  logic [9:0]                       v_cnt,
  output logic                             hit,
  output logic [$clog2(COLS*ROWS)-1:0]     pos,
  output logic [$clog2(CARD_W)-1:0]        px,
  output logic [5:0]                       py
);

  localparam int POS_W = $clog2(COLS * ROWS);
  localparam int PX_W  = $clog2(CARD_W);
  localparam int X_END = X0 + COLS * CARD_W;

  logic [31:0] h32;
  logic [31:0] v32;
  logic [31:0] col_idx;
  logic [31:0] row_idx;
  logic [31:0] top_sel;
  logic        col_ok;
  logic        row_ok;

  assign h32 = 32'(h_cnt);
  assign v32 = 32'(v_cnt);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // that no path leaves a value unassigned and no latch is inferred.
    row_ok  = 1'b0;
    row_idx = '0;
    top_sel = '0;
    col_ok  = (h32 >= 32'(X0)) && (h32 < 32'(X_END));
    col_idx = (h32 - 32'(X0)) >> PX_W;

    // Rows never overlap, because CARD_H is smaller than the pitch. At most
    // one comparator matches.
    for (int r = 0; r < ROWS; r++) begin
      if ((v32 >= 32'(row_top(r, Y0, ROW_PITCH, GAP_ROW, GAP_EXTRA))) &&
          (v32 <  32'(row_top(r, Y0, ROW_PITCH, GAP_ROW, GAP_EXTRA) + CARD_H))) begin
        row_ok  = 1'b1;
        row_idx = 32'(r);
        top_sel = 32'(row_top(r, Y0, ROW_PITCH, GAP_ROW, GAP_EXTRA));
      end
    end

    hit = col_ok && row_ok;
    pos = '0;
    px  = '0;
    py  = '0;
    if (hit) begin
      pos = POS_W'(row_idx * 32'(COLS) + col_idx);
      px  = PX_W'(h32 - 32'(X0));
      py  = 6'(v32 - top_sel);
    end
  end

endmodule

// File: rtl/display_card_grid.sv
// Pipelined card-grid renderer for the VGA path.
//
// Stage 0 (comb) : locate the slot, px and py from h_cnt/v_cnt.
// Stage 1 (reg)  : drive the card-image ROM address. Latch the frame,
//                  selection and cursor flags.
// Stage 2 (reg)  : choose the pixel source. The ROM data arrives in the same
//                  cycle, so card_pixel is a mux of the registered source and
//                  rom_pixel.
// Total latency from h_cnt/v_cnt to card_pixel is 2 clk.
//
// Ports:
//   clk, rst            : pixel clock, synchronous active-high reset
//   map, sel_card       : per-slot card type and selection flag
//   cursor_en/pos       : blinking cursor frame enable and slot
//   h_cnt, v_cnt        : VGA pixel counters
//   rom_card_type/x/y   : card-image ROM address (registered)
//   rom_pixel           : ROM data, valid one clk after the address
//   card_pixel, card_hit: composited colour, pixel lies inside a card
module display_card_grid
  import display_pkg::*;
#(
  parameter int          COLS         = DEF_COLS,
  parameter int          ROWS         = DEF_ROWS,
  parameter int          TYPE_W       = DEF_TYPE_W,
  parameter int          CARD_W       = DEF_CARD_W,
  parameter int          CARD_H       = DEF_CARD_H,
  parameter int          X0           = DEF_X0,
  parameter int          Y0           = DEF_Y0,
  parameter int          ROW_PITCH    = DEF_ROW_PITCH,
  parameter int          GAP_ROW      = DEF_GAP_ROW,
  parameter int          GAP_EXTRA    = DEF_GAP_EXTRA,
  parameter int          EMPTY_TYPE   = DEF_EMPTY_TYPE,
  parameter int          FRAME_T      = DEF_FRAME_T,
  parameter int          BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter logic [11:0] FRAME_COLOR  = DEF_FRAME_COLOR,
  parameter logic [11:0] CURSOR_COLOR = DEF_CURSOR_COLOR,
  parameter logic [11:0] BG_COLOR     = DEF_BG_COLOR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COLS*ROWS*TYPE_W-1:0]       map,
  input  logic [COLS*ROWS-1:0]              sel_card,
  input  logic                              cursor_en,
  input  logic [$clog2(COLS*ROWS)-1:0]      cursor_pos,
  input  logic [9:0]                        h_cnt,
  input  logic [9:0]                        v_cnt,
  output logic [TYPE_W-1:0]                 rom_card_type,
  output logic [$clog2(CARD_W)-1:0]         rom_pixel_x,
  output logic [5:0]                        rom_pixel_y,
  input  logic [11:0]                       rom_pixel,
  output logic [11:0]                       card_pixel,
  output logic                              card_hit
);

  localparam int N_SLOTS = COLS * ROWS;
  localparam int POS_W   = $clog2(N_SLOTS);
  localparam int PX_W    = $clog2(CARD_W);
  localparam int BLINK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 0: locate
  logic              loc_hit;
  logic [POS_W-1:0]  loc_pos;
  logic [PX_W-1:0]   loc_px;
  logic [5:0]        loc_py;

  card_grid_locate #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .CARD_W    (CARD_W),
    .CARD_H    (CARD_H),
    .X0        (X0),
    .Y0        (Y0),
    .ROW_PITCH (ROW_PITCH),
    .GAP_ROW   (GAP_ROW),
    .GAP_EXTRA (GAP_EXTRA)
  ) u_locate (
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .hit   (loc_hit),
    .pos   (loc_pos),
    .px    (loc_px),
    .py    (loc_py)
  );

  // Stage 1: slot lookup and per-pixel flags
  logic [TYPE_W-1:0] type_d;
  logic              sel_d;
  logic              frame_d;
  logic              cur_d;

  logic              s1_hit_q;
  logic              s1_frame_q;
  logic              s1_sel_q;
  logic              s1_cur_q;
  logic [TYPE_W-1:0] rom_type_q;
  logic [PX_W-1:0]   rom_x_q;
  logic [5:0]        rom_y_q;

  always_comb begin
    type_d = '0;
    sel_d  = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (loc_pos == POS_W'(i)) begin
        type_d = map[i*TYPE_W +: TYPE_W];
        sel_d  = sel_card[i];
      end
    end

    frame_d = (32'(loc_px) <  32'(FRAME_T))          ||
              (32'(loc_px) >= 32'(CARD_W - FRAME_T)) ||
              (32'(loc_py) <  32'(FRAME_T))          ||
              (32'(loc_py) >= 32'(CARD_H - FRAME_T));

    // An out-of-range cursor index never matches any slot.
    cur_d = cursor_en && (cursor_pos == loc_pos) &&
            (32'(cursor_pos) < 32'(N_SLOTS));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values sampled before the edge.
    if (rst || !loc_hit) begin
      s1_hit_q   <= 1'b0;
      s1_frame_q <= 1'b0;
      s1_sel_q   <= 1'b0;
      s1_cur_q   <= 1'b0;
      rom_type_q <= '0;
      rom_x_q    <= '0;
      rom_y_q    <= '0;
    end else begin
      s1_hit_q   <= 1'b1;
      s1_frame_q <= frame_d;
      s1_sel_q   <= sel_d && (type_d != TYPE_W'(EMPTY_TYPE));
      s1_cur_q   <= cur_d;
      rom_type_q <= type_d;
      rom_x_q    <= loc_px;
      rom_y_q    <= loc_py;
    end
  end

  assign rom_card_type = rom_type_q;
  assign rom_pixel_x   = rom_x_q;
  assign rom_pixel_y   = rom_y_q;

  // Blink timer: counts frame starts and toggles the phase every
  // BLINK_FRAMES frames. Disabling the cursor parks the timer, so after
  // re-enable the cursor stays hidden for a full half-period.
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic               frame_start;

  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_ff @(posedge clk) begin
    if (rst || !cursor_en) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Stage 2: compositing priority, resolved from the stage-1 flags
  pix_src_e src_d;
  pix_src_e src_q;

  always_comb begin
    src_d = SRC_ROM;
    if (!s1_hit_q) begin
      src_d = SRC_BG;
    end else if (s1_cur_q && blink_phase_q && s1_frame_q) begin
      src_d = SRC_CURSOR;
    end else if (s1_sel_q && s1_frame_q) begin
      src_d = SRC_FRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= SRC_BG;
    end else begin
      src_q <= src_d;
    end
  end

  // The ROM data for this pixel arrives in the same cycle as src_q. The
  // final mux therefore stays combinational on the ROM output.
  always_comb begin
    card_pixel = BG_COLOR;
    case (src_q)
      SRC_ROM:    card_pixel = rom_pixel;
      SRC_FRAME:  card_pixel = FRAME_COLOR;
      SRC_CURSOR: card_pixel = CURSOR_COLOR;
      default:    card_pixel = BG_COLOR;
    endcase
  end

  assign card_hit = (src_q != SRC_BG);

endmodule

// File: tb/tb_display_card_grid.sv
module tb_display_card_grid;
  import display_pkg::*;

  localparam int N = 144;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*6-1:0] map;
  logic [N-1:0]  sel_card;
  logic          cursor_en;
  logic [7:0]    cursor_pos;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [5:0]    rom_card_type;
  logic [4:0]    rom_pixel_x;
  logic [5:0]    rom_pixel_y;
  logic [11:0]   rom_pixel;
  logic [11:0]   card_pixel;
  logic          card_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_card_grid #(.BLINK_FRAMES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .map           (map),
    .sel_card      (sel_card),
    .cursor_en     (cursor_en),
    .cursor_pos    (cursor_pos),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .rom_card_type (rom_card_type),
    .rom_pixel_x   (rom_pixel_x),
    .rom_pixel_y   (rom_pixel_y),
    .rom_pixel     (rom_pixel),
    .card_pixel    (card_pixel),
    .card_hit      (card_hit)
  );

  // Card-image ROM model: synchronous, data one clk after the address
  function automatic logic [11:0] rom_fn(input logic [5:0] t, input logic [4:0] x,
                                         input logic [5:0] y);
    return {t, y} ^ {6'b0, x, 1'b0};
  endfunction

  always @(posedge clk) rom_pixel <= rom_fn(rom_card_type, rom_pixel_x, rom_pixel_y);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hv(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
  endtask

  task automatic set_type(input int slot, input int t);
    map[slot*6 +: 6] = 6'(t);
  endtask

  task automatic frame_start();
    set_hv(0, 0);
    step();
  endtask

  task automatic probe(input string name, input int h, input int v, input logic [11:0] exp_pix);
    set_hv(h, v);
    step();
    step();
    check(name, 32'(card_pixel), 32'(exp_pix));
  endtask

  // src: 0 background, 1 ROM pixel, 2 selection frame
  typedef struct {
    int h;
    int v;
    int hit;
    int typ;
    int px;
    int py;
    int src;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [11:0] exp_pix;

    vecs[0]  = '{40,  30,  1, 5,  8,  11, 1};
    vecs[1]  = '{100, 350, 0, 0,  0,  0,  0};
    vecs[2]  = '{32,  360, 1, 7,  0,  0,  2};
    vecs[3]  = '{64,  74,  1, 3,  0,  0,  2};
    vecs[4]  = '{80,  90,  1, 3,  16, 16, 1};
    vecs[5]  = '{607, 19,  1, 9,  31, 0,  1};
    vecs[6]  = '{608, 19,  0, 0,  0,  0,  0};
    vecs[7]  = '{31,  30,  0, 0,  0,  0,  0};
    vecs[8]  = '{80,  119, 1, 3,  16, 45, 2};
    vecs[9]  = '{80,  120, 0, 0,  0,  0,  0};
    vecs[10] = '{40,  18,  0, 0,  0,  0,  0};
    vecs[11] = '{33,  361, 1, 7,  1,  1,  2};
    vecs[12] = '{34,  362, 1, 7,  2,  2,  1};
    vecs[13] = '{600, 460, 1, 54, 24, 45, 1};
    vecs[14] = '{63,  129, 1, 54, 31, 0,  1};
    vecs[15] = '{40,  339, 1, 54, 8,  45, 1};
    vecs[16] = '{40,  340, 0, 0,  0,  0,  0};

    for (int i = 0; i < N; i++) set_type(i, 54);
    set_type(0, 5);
    set_type(17, 9);
    set_type(19, 3);
    set_type(108, 7);
    sel_card      = '0;
    sel_card[19]  = 1'b1;
    sel_card[108] = 1'b1;
    cursor_en     = 1'b0;
    cursor_pos    = 8'd19;
    rst           = 1'b1;
    set_hv(0, 0);

    // Reset held for 3 clk while h/v sweep over a card
    for (int k = 0; k < 3; k++) begin
      set_hv(40 + k, 30);
      step();
      check("rst_card_hit", 32'(card_hit), 0);
      check("rst_card_pixel", 32'(card_pixel), 0);
      check("rst_rom_type", 32'(rom_card_type), 0);
      check("rst_rom_x", 32'(rom_pixel_x), 0);
      check("rst_rom_y", 32'(rom_pixel_y), 0);
    end
    set_hv(40, 30);
    rst = 1'b0;
    step();
    check("rel_rom_type_1clk", 32'(rom_card_type), 5);
    check("rel_card_hit_1clk", 32'(card_hit), 0);
    step();
    check("rel_card_hit_2clk", 32'(card_hit), 1);
    check("rel_card_pixel_2clk", 32'(card_pixel), 32'(rom_fn(6'd5, 5'd8, 6'd11)));

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      set_hv(vecs[i].h, vecs[i].v);
      step();
      check($sformatf("v%0d_rom_type", i), 32'(rom_card_type), 32'(vecs[i].typ));
      check($sformatf("v%0d_rom_x", i), 32'(rom_pixel_x), 32'(vecs[i].px));
      check($sformatf("v%0d_rom_y", i), 32'(rom_pixel_y), 32'(vecs[i].py));
      step();
      case (vecs[i].src)
        1:       exp_pix = rom_fn(6'(vecs[i].typ), 5'(vecs[i].px), 6'(vecs[i].py));
        2:       exp_pix = 12'hFEC;
        default: exp_pix = 12'h000;
      endcase
      check($sformatf("v%0d_card_hit", i), 32'(card_hit), 32'(vecs[i].hit));
      check($sformatf("v%0d_card_pixel", i), 32'(card_pixel), 32'(exp_pix));
    end

    // Back-to-back pixels: exact 2-clk latency
    set_hv(40, 30);
    step();
    set_hv(100, 350);
    step();
    check("lat_a_hit", 32'(card_hit), 1);
    check("lat_a_pixel", 32'(card_pixel), 32'(rom_fn(6'd5, 5'd8, 6'd11)));
    set_hv(64, 74);
    step();
    check("lat_b_hit", 32'(card_hit), 0);
    check("lat_b_pixel", 32'(card_pixel), 0);
    set_hv(100, 350);
    step();
    check("lat_c_pixel", 32'(card_pixel), 32'h0FEC);

    // A selected slot holding no card shows no selection frame
    set_type(19, 54);
    probe("empty_sel_pixel", 64, 74, rom_fn(6'd54, 5'd0, 6'd0));
    check("empty_sel_hit", 32'(card_hit), 1);
    set_type(19, 3);

    // Blink sequence, BLINK_FRAMES=2: frames 0-1 hidden, 2-3 shown, 4-5 hidden
    set_hv(64, 74);
    cursor_en = 1'b1;
    probe("blink_f0", 64, 74, 12'hFEC);
    frame_start();
    probe("blink_f1", 64, 74, 12'hFEC);
    frame_start();
    probe("blink_f2", 64, 74, 12'h0F0);
    probe("blink_f2_interior", 80, 90, rom_fn(6'd3, 5'd16, 6'd16));
    cursor_pos = 8'd20;
    probe("blink_f2_empty_slot", 96, 74, 12'h0F0);
    cursor_pos = 8'd144;
    probe("blink_f2_pos_oob", 64, 74, 12'hFEC);
    cursor_pos = 8'd19;
    frame_start();
    probe("blink_f3", 64, 74, 12'h0F0);
    frame_start();
    probe("blink_f4", 64, 74, 12'hFEC);
    frame_start();
    probe("blink_f5", 64, 74, 12'hFEC);
    frame_start();
    probe("blink_f6", 64, 74, 12'h0F0);
    frame_start();
    probe("blink_f7", 64, 74, 12'h0F0);

    // Drop the enable mid-frame: the timer clears on the next clk
    cursor_en = 1'b0;
    step();
    check("drop_blink_cnt", 32'(dut.blink_cnt_q), 0);
    check("drop_blink_phase", 32'(dut.blink_phase_q), 0);
    probe("drop_pixel", 64, 74, 12'hFEC);

    // Re-enable: hidden for a full half-period, then shown
    cursor_en = 1'b1;
    probe("reen_f0", 64, 74, 12'hFEC);
    frame_start();
    probe("reen_f1", 64, 74, 12'hFEC);
    frame_start();
    probe("reen_f2", 64, 74, 12'h0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
